// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcodes, FSM states and op classification.
package alu_pkg;

  typedef enum logic [4:0] {
    ADD    = 5'd0,
    SUB    = 5'd1,
    SLL    = 5'd2,
    SLT    = 5'd3,
    SLTU   = 5'd4,
    XOR    = 5'd5,
    SRL    = 5'd6,
    SRA    = 5'd7,
    OR     = 5'd8,
    AND    = 5'd9,
    PASS_B = 5'd10,
    MUL    = 5'd16,
    MULH   = 5'd17,
    MULHSU = 5'd18,
    MULHU  = 5'd19,
    DIV    = 5'd20,
    DIVU   = 5'd21,
    REM    = 5'd22,
    REMU   = 5'd23
  } alu_op_e;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  function automatic logic is_multicycle(alu_op_e op);
    case (op)
      MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU: is_multicycle = 1'b1;
      default:                                       is_multicycle = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative M-extension engine: shift-add multiply and restoring divide on
// magnitudes, one bit per cycle, sharing a 2*XLEN accumulator and bit counter.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CNT_W = $clog2(XLEN) + 1;

  logic              busy;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  alu_op_e           op_q;
  logic              is_mul_q, neg_q, neg_r, div0;

  logic              a_sgn, b_sgn, a_neg, b_neg, is_mul;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     sum, rem_sh;
  logic [XLEN-1:0]   diff;
  logic              ge;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem;

  assign is_mul = (op == MUL) || (op == MULH) || (op == MULHSU) || (op == MULHU);
  assign a_sgn  = (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
  assign b_sgn  = (op == MULH) || (op == DIV) || (op == REM);
  assign a_neg  = a_sgn & a[XLEN-1];
  assign b_neg  = b_sgn & b[XLEN-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;

  assign sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
  // The shifted partial remainder needs one extra bit; when it fits the
  // divisor the difference is always below the divisor, so XLEN bits suffice.
  assign rem_sh = acc[2*XLEN-1:XLEN-1];
  assign ge     = rem_sh >= {1'b0, opnd};
  assign diff   = rem_sh[XLEN-1:0] - opnd;

  assign done   = busy && (cnt == CNT_W'(XLEN));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      op_q     <= MUL;
      is_mul_q <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div0     <= 1'b0;
    end else if (start) begin
      busy     <= 1'b1;
      cnt      <= '0;
      acc      <= {{XLEN{1'b0}}, is_mul ? b_mag : a_mag};
      opnd     <= is_mul ? a_mag : b_mag;
      op_q     <= op;
      is_mul_q <= is_mul;
      neg_q    <= a_neg ^ b_neg;
      neg_r    <= a_neg;
      div0     <= (b == '0);
    end else if (done) begin
      busy <= 1'b0;
    end else if (busy) begin
      cnt <= cnt + 1'b1;
      if (is_mul_q) acc <= {sum, acc[XLEN-1:1]};
      else          acc <= {ge ? diff : rem_sh[XLEN-1:0], acc[XLEN-2:0], ge};
    end
  end

  assign prod = neg_q ? -acc : acc;
  assign quot = acc[XLEN-1:0];
  assign rem  = acc[2*XLEN-1:XLEN];

  always_comb begin
    result = '0;
    case (op_q)
      MUL:                 result = prod[XLEN-1:0];
      MULH, MULHSU, MULHU: result = prod[2*XLEN-1:XLEN];
      DIV, DIVU:           result = div0 ? '1 : (neg_q ? -quot : quot);
      REM, REMU:           result = neg_r ? -rem : rem;
      default:             result = '0;
    endcase
  end

endmodule

// File: rtl/alu_mc.sv
// Handshaked RV32I ALU with optional iterative M-extension engine.
// Define ALU_MULDIV_EN to build the BUSY state and the alu_muldiv_iter engine.
module alu_mc
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] alu_src1,
  input  logic [XLEN-1:0] alu_src2,
  input  logic [4:0]      alu_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic            equal
);
  localparam int SHAMT_W = $clog2(XLEN);

  state_e          state, state_nxt;
  alu_op_e         op;
  logic            accept, mc_op, eng_start, eng_done;
  logic [XLEN-1:0] eng_result, sc_result;
  logic [SHAMT_W-1:0] shamt;

  assign op     = alu_op_e'(alu_op);
  assign shamt  = alu_src2[SHAMT_W-1:0];
  assign accept = in_valid && in_ready;

`ifdef ALU_MULDIV_EN
  assign mc_op = is_multicycle(op);

  alu_muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .start  (eng_start),
    .op     (op),
    .a      (alu_src1),
    .b      (alu_src2),
    .done   (eng_done),
    .result (eng_result)
  );
`else
  assign mc_op      = 1'b0;
  assign eng_done   = 1'b0;
  assign eng_result = '0;
`endif

  always_comb begin
    sc_result = '0;
    case (op)
      ADD:     sc_result = alu_src1 + alu_src2;
      SUB:     sc_result = alu_src1 - alu_src2;
      SLL:     sc_result = alu_src1 << shamt;
      SLT:     sc_result = XLEN'($signed(alu_src1) < $signed(alu_src2));
      SLTU:    sc_result = XLEN'(alu_src1 < alu_src2);
      XOR:     sc_result = alu_src1 ^ alu_src2;
      SRL:     sc_result = alu_src1 >> shamt;
      SRA:     sc_result = XLEN'($signed(alu_src1) >>> shamt);
      OR:      sc_result = alu_src1 | alu_src2;
      AND:     sc_result = alu_src1 & alu_src2;
      PASS_B:  sc_result = alu_src2;
      default: sc_result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    eng_start = 1'b0;
    case (state)
      IDLE, DONE: begin
        in_ready  = (state == IDLE) || out_ready;
        out_valid = (state == DONE);
        eng_start = in_valid && in_ready && mc_op;
        if (in_valid && in_ready)            state_nxt = mc_op ? BUSY : DONE;
        else if (state == DONE && out_ready) state_nxt = IDLE;
      end
      BUSY:    if (eng_done) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Result and flag only change on an accept or engine completion, so they
  // stay stable in DONE until the consumer retires them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_result <= '0;
      equal      <= 1'b0;
    end else if (accept) begin
      equal <= (alu_src1 == alu_src2);
      if (!mc_op) alu_result <= sc_result;
    end else if (state == BUSY && eng_done) begin
      alu_result <= eng_result;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed table-driven bench for alu_mc plus handshake/reset corner sequences.
module tb_alu_mc;
  import alu_pkg::*;

`ifdef ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, equal;
  logic [31:0] alu_src1, alu_src2, alu_result;
  logic [4:0]  alu_op;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  alu_mc #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_op(alu_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_result(alu_result), .equal(equal)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sv(input logic [4:0] op, input logic [31:0] a, b, res);
    vecs.push_back('{op, a, b, res, 1});
  endtask

  task automatic mv(input logic [4:0] op, input logic [31:0] a, b, res);
    vecs.push_back('{op, a, b, MD ? res : 32'h0, MD ? 33 : 1});
  endtask

  // Issue one op (waits for in_ready), then count negedges until out_valid.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, b,
                        output logic [31:0] res, output logic eq,
                        output int lat, output int busy_rdy);
    int w;
    @(negedge clk);
    in_valid = 1'b1; alu_op = op; alu_src1 = a; alu_src2 = b;
    w = 0;
    while (!in_ready && w < 100) begin @(negedge clk); w++; end
    if (w >= 100) chk("accept_timeout", 32'(w), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; alu_src1 = 32'hDEAD_BEEF; alu_src2 = 32'h1234_5678;
    lat = 0; busy_rdy = 0;
    while (lat < 100) begin
      @(negedge clk); lat++;
      if (out_valid) break;
      if (in_ready) busy_rdy++;
    end
    res = alu_result; eq = equal;
  endtask

  initial begin
    logic [31:0] r;
    logic        e;
    int          lat, br;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = 5'd0; alu_src1 = '0; alu_src2 = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", alu_result, 32'h0);
    chk("rst_equal", 32'(equal), 32'd0);
    reset = 1'b0;

    sv(ADD,    32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
    sv(SRA,    32'h8000_0000, 32'h0000_0024, 32'hF800_0000);
    sv(SLTU,   32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001);
    sv(SUB,    32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE);
    sv(SLL,    32'h0000_0001, 32'h0000_0021, 32'h0000_0002);
    sv(SRL,    32'h8000_0000, 32'h0000_0004, 32'h0800_0000);
    sv(SLT,    32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
    sv(XOR,    32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
    sv(OR,     32'h1234_5678, 32'h0F0F_0F0F, 32'h1F3F_5F7F);
    sv(AND,    32'hFFFF_0000, 32'h1234_5678, 32'h1234_0000);
    sv(PASS_B, 32'h0000_0000, 32'hABCD_E000, 32'hABCD_E000);
    sv(5'd11,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000);
    sv(ADD,    32'h0000_0003, 32'h0000_0003, 32'h0000_0006);
    mv(MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF);
    mv(MUL,    32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1);
    mv(MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    mv(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    mv(DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    mv(REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    mv(DIVU,   32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF);
    mv(DIV,    32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF);
    mv(REM,    32'h0000_0007, 32'h0000_0000, 32'h0000_0007);
    mv(DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD);
    mv(REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF);
    mv(REMU,   32'h0000_0064, 32'h0000_0007, 32'h0000_0002);
    mv(DIVU,   32'hFFFF_FFFF, 32'h0000_000A, 32'h1999_9999);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, e, lat, br);
      chk($sformatf("v%0d_result", i), r, vecs[i].res);
      chk($sformatf("v%0d_equal", i), 32'(e), 32'(vecs[i].a == vecs[i].b));
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_busy_ready", i), 32'(br), 32'd0);
    end
    @(negedge clk);
    chk("idle_after_retire", 32'(out_valid), 32'd0);

    // Back-to-back single-cycle ops: one result per cycle.
    @(negedge clk);
    in_valid = 1'b1; alu_op = SRA; alu_src1 = 32'h8000_0000; alu_src2 = 32'h24;
    @(negedge clk);
    chk("b2b_ready", 32'(in_ready), 32'd1);
    chk("b2b_v0", 32'(out_valid), 32'd1);
    chk("b2b_r0", alu_result, 32'hF800_0000);
    alu_op = SLTU; alu_src1 = 32'h1; alu_src2 = 32'hFFFF_FFFF;
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_v1", 32'(out_valid), 32'd1);
    chk("b2b_r1", alu_result, 32'h1);
    @(negedge clk);
    chk("b2b_drain", 32'(out_valid), 32'd0);

    // Consumer stall on DIV, then retire+accept REM on the same edge.
    out_ready = 1'b0;
    run_op(DIV, 32'd100, 32'd7, r, e, lat, br);
    chk("stall_lat", 32'(lat), MD ? 32'd33 : 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("stall%0d_result", k), alu_result, MD ? 32'd14 : 32'd0);
      chk($sformatf("stall%0d_ready", k), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    run_op(REM, 32'd100, 32'd7, r, e, lat, br);
    chk("rem_after_retire", r, MD ? 32'd2 : 32'd0);
    chk("rem_lat", 32'(lat), MD ? 32'd33 : 32'd1);

    // Reset ten cycles into a MUL must abort it without a result.
    @(negedge clk);
    in_valid = 1'b1; alu_op = MUL; alu_src1 = 32'd7; alu_src2 = 32'd6;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    br = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid || !in_ready) br++;
    end
    chk("abort_no_result", 32'(br), 32'd0);
    chk("abort_result_cleared", alu_result, 32'h0);
    run_op(ADD, 32'd2, 32'd3, r, e, lat, br);
    chk("post_rst_add", r, 32'd5);
    chk("post_rst_lat", 32'(lat), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, handshaked successor to the single-cycle ALU in the Eka execute stage.
- Executes the full RV32I register/immediate ALU op set in one registered cycle.
- Executes M-extension multiply/divide ops iteratively over multiple cycles.
- valid/ready on both sides lets the execute stage stall on long ops.

Parameters:
- XLEN, 32, operand/result width; must be a power of two ≥ 8.
- SHAMT_W, $clog2(XLEN), shift-amount width; derived localparam, not overridable.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and op presented.
- in_ready  out  1  block can accept an op this cycle.
- alu_src1  in  XLEN  operand A (rs1/PC).
- alu_src2  in  XLEN  operand B (rs2/imm).
- alu_op  in  5  operation code, alu_op_e from alu_pkg.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result this cycle.
- alu_result  out  XLEN  registered result.
- equal  out  1  registered flag: 1 when the accepted src1 == src2.

Behaviour:
- Reset: state=IDLE; in_ready=1; out_valid=0; alu_result=0; equal=0. Asserting reset mid-operation aborts the op; no result is ever presented for it.
- States:
  - IDLE: in_ready=1. Accept when in_valid&&in_ready.
    - Single-cycle op goes to DONE; result is registered at the accept edge.
    - MUL/DIV op goes to BUSY; the engine is loaded at the accept edge.
  - BUSY: in_ready=0. The engine processes 1 bit per cycle for XLEN cycles, then the result is registered and the state goes to DONE.
  - DONE: out_valid=1; alu_result and equal are held stable until out_ready.
    - out_ready=1 with no new accept goes to IDLE.
    - in_ready = out_ready in DONE: a simultaneous retire+accept is legal and follows the IDLE accept rules (back-to-back single-cycle ops give 1 result/cycle).
- Latency (accept edge to out_valid):
  - Single-cycle ops: 1 cycle.
  - MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU: XLEN+1 cycles.
- Ops:
  - ADD, SUB: modulo 2^XLEN, no flags.
  - SLL, SRL, SRA: shift amount = src2[SHAMT_W-1:0]; upper bits are ignored.
  - SLT, SLTU: result 1 or 0, zero-extended.
  - XOR, OR, AND.
  - PASS_B: result = src2 (used for LUI).
  - MUL: low XLEN bits of the product.
  - MULH, MULHSU, MULHU: high XLEN bits of the 2*XLEN product, signed×signed, signed×unsigned, unsigned×unsigned respectively.
  - The engine works on magnitudes; the sign is fixed in the final cycle.
- Divide corner cases:
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = src1.
  - Signed overflow (src1 = most negative, src2 = -1): DIV = src1, REM = 0.
  - Corner cases still take the full XLEN+1 latency, so latency is fixed per op class.
- Illegal alu_op: result 0, latency 1, no error signal.
- equal is computed on the operands captured at accept, for every op.
- Inputs are sampled only at the accept edge; changes to them while BUSY are ignored.

Optional Feature:
- ALU_MULDIV_EN defined: M-extension ops are supported as above; the BUSY state and the alu_muldiv_iter engine are instantiated.
- ALU_MULDIV_EN undefined: M opcodes are treated as illegal (result 0, latency 1). The BUSY state and the engine are absent, and in_ready depends only on IDLE/DONE.

Decomposition:
- alu_pkg holds:
  - typedef enum logic [4:0] alu_op_e (ADD=0, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B, MUL=16, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
  - typedef state_e {IDLE, BUSY, DONE}.
  - Function is_multicycle(alu_op_e).
- One sub-module, alu_muldiv_iter:
  - Shift-add multiplier and restoring divider sharing one 2*XLEN accumulator and one bit counter.
  - Interface: start/op/operands in; done/result out.

Test Plan:
- Reset then ADD 0x7FFF_FFFF + 1, out_ready=1: out_valid exactly 1 cycle after accept; result 0x8000_0000; equal=0.
- SRA 0x8000_0000 by src2=0x0000_0024 (shamt 4): result 0xF800_0000. SLTU 1 vs 0xFFFF_FFFF: result 1. Issue both back-to-back with out_ready=1: 2 results on 2 consecutive cycles.
- MULHSU 0xFFFF_FFFF × 0x0000_0002: result 0xFFFF_FFFF after 33 cycles; in_ready=0 throughout BUSY.
- DIV 0x8000_0000 / 0xFFFF_FFFF: result 0x8000_0000. DIVU 5 / 0: result 0xFFFF_FFFF. REM 7 / 0: result 7.
- DIV 100 / 7 with out_ready held 0 for 5 cycles after out_valid: result 14 stable, in_ready=0 until out_ready=1. Then REM 100 / 7 accepted on the retire cycle: result 2.
- Assert reset at cycle 10 of a MUL: out_valid stays 0, state IDLE. A following ADD 2+3 returns 5 with 1-cycle latency.
